// File: rtl/eq_pkg.sv
// Shared equalizer types: band sample/index typedefs and the band meter FSM states.
package eq_pkg;

    localparam int unsigned EQ_NBANDS = 8;
    localparam int unsigned EQ_DATA_W = 16;

    typedef logic signed [15:0] eq_sample_t;
    typedef logic [2:0]         eq_band_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DUMP  = 2'd2
    } meter_state_t;

endpackage

// File: rtl/eq_abs_sat.sv
// Combinational saturating absolute value: the most negative input maps to the
// largest positive value so the result always fits in DATA_W-1 magnitude bits.
module eq_abs_sat #(
    parameter int unsigned DATA_W = 16
) (
    input  logic signed [DATA_W-1:0] x,
    output logic        [DATA_W-1:0] abs_c
);

    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] x_u;

    assign x_u = x;

    always_comb begin
        abs_c = x_u;
        if (x_u[DATA_W-1]) begin
            abs_c = (x_u == MOST_NEG) ? ~MOST_NEG : (~x_u + DATA_W'(1));
        end
    end

endmodule

// File: rtl/eq_band_meter.sv
// Per-band mean-absolute level meter with one time-shared abs/accumulate datapath.
// Optional per-band peak output when EQ_METER_PEAK_EN is defined.
module eq_band_meter
    import eq_pkg::*;
#(
    parameter int unsigned DATA_W   = EQ_DATA_W,
    parameter int unsigned NBANDS   = EQ_NBANDS,
    parameter int unsigned WIN_LOG2 = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NBANDS-1:0][DATA_W-1:0]  band,
    output logic                           lvl_valid,
    input  logic                           lvl_ready,
    output logic [2:0]                     lvl_band,
    output logic [DATA_W-1:0]              lvl_data,
    output logic                           lvl_last
`ifdef EQ_METER_PEAK_EN
    ,
    output logic [DATA_W-1:0]              lvl_peak
`endif
);

    localparam int unsigned ACC_W    = DATA_W + WIN_LOG2;
    localparam logic [2:0]  LAST_IDX = 3'(NBANDS - 1);

    meter_state_t             state;
    logic [2:0]               idx;
    logic [2:0]               idx_nxt_c;
    logic [WIN_LOG2-1:0]      cnt;
    logic signed [DATA_W-1:0] band_hold [NBANDS];
    logic [ACC_W-1:0]         acc [NBANDS];
    logic [DATA_W-1:0]        abs_c;
    logic                     win_done_c;
    logic                     dump_hs_c;

    assign idx_nxt_c  = idx + 3'd1;
    // last accumulate step of the final sample in the window
    assign win_done_c = (state == ACCUM) && (idx == LAST_IDX) && (cnt == '1);
    assign dump_hs_c  = (state == DUMP) && lvl_valid && lvl_ready;

    eq_abs_sat #(
        .DATA_W (DATA_W)
    ) u_abs_sat (
        .x     (band_hold[idx]),
        .abs_c (abs_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            lvl_valid <= 1'b0;
            lvl_band  <= '0;
            lvl_data  <= '0;
            lvl_last  <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            for (int unsigned i = 0; i < NBANDS; i++) begin
                acc[i]       <= '0;
                band_hold[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        for (int unsigned i = 0; i < NBANDS; i++) begin
                            band_hold[i] <= band[i];
                        end
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc[idx] <= acc[idx] + ACC_W'(abs_c);
                    if (idx == LAST_IDX) begin
                        cnt <= cnt + WIN_LOG2'(1);
                        if (win_done_c) begin
                            // band 0 finished accumulating 7 edges ago, so its mean is ready now
                            state     <= DUMP;
                            idx       <= '0;
                            lvl_valid <= 1'b1;
                            lvl_band  <= '0;
                            lvl_data  <= DATA_W'(acc[0] >> WIN_LOG2);
                            lvl_last  <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        idx <= idx_nxt_c;
                    end
                end
                DUMP: begin
                    if (dump_hs_c) begin
                        acc[idx] <= '0;
                        if (idx == LAST_IDX) begin
                            state     <= IDLE;
                            lvl_valid <= 1'b0;
                            lvl_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            idx       <= '0;
                        end else begin
                            idx      <= idx_nxt_c;
                            lvl_band <= idx_nxt_c;
                            lvl_data <= DATA_W'(acc[idx_nxt_c] >> WIN_LOG2);
                            lvl_last <= (idx_nxt_c == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef EQ_METER_PEAK_EN
    logic [DATA_W-1:0] peak [NBANDS];

    // peak tracking shares the abs result and follows the same index/handshake as the sums
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl_peak <= '0;
            for (int unsigned i = 0; i < NBANDS; i++) begin
                peak[i] <= '0;
            end
        end else begin
            if ((state == ACCUM) && (abs_c > peak[idx])) begin
                peak[idx] <= abs_c;
            end
            if (win_done_c) begin
                lvl_peak <= peak[0];
            end
            if (dump_hs_c) begin
                peak[idx] <= '0;
                if (idx != LAST_IDX) begin
                    lvl_peak <= peak[idx_nxt_c];
                end
            end
        end
    end
`else
    // without peak tracking the level stream carries only the mean level
`endif

endmodule

// File: tb/tb_eq_band_meter.sv
// Scoreboard bench for eq_band_meter with a 4-sample window (WIN_LOG2=2).
// Define EQ_METER_PEAK_EN for both RTL and bench to exercise the peak output.
module tb_eq_band_meter;

    localparam int CYC_LIM = 200;
    localparam int WIN     = 4;

    typedef logic [7:0][15:0] vec_t;
    typedef struct {
        int band;
        int data;
        bit last;
        int peak;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    vec_t        band;
    logic        lvl_valid;
    logic        lvl_ready;
    logic [2:0]  lvl_band;
    logic [15:0] lvl_data;
    logic        lvl_last;
`ifdef EQ_METER_PEAK_EN
    logic [15:0] lvl_peak;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    exp_t sb[$];
    int   model_acc [8];
    int   model_peak [8];
    int   model_cnt = 0;

    eq_band_meter #(
        .DATA_W   (16),
        .NBANDS   (8),
        .WIN_LOG2 (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .band      (band),
        .lvl_valid (lvl_valid),
        .lvl_ready (lvl_ready),
        .lvl_band  (lvl_band),
        .lvl_data  (lvl_data),
        .lvl_last  (lvl_last)
`ifdef EQ_METER_PEAK_EN
        ,
        .lvl_peak  (lvl_peak)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int absm(input int x);
        int a;
        a = (x < 0) ? -x : x;
        if (a > 32767) a = 32767;
        return a;
    endfunction

    task automatic model_clear();
        for (int b = 0; b < 8; b++) begin
            model_acc[b]  = 0;
            model_peak[b] = 0;
        end
        model_cnt = 0;
        sb.delete();
    endtask

    // drive one band vector, wait (bounded) for acceptance, update the reference model
    task automatic put_sample(input vec_t v);
        int n;
        exp_t e;
        n = 0;
        band = v;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < CYC_LIM) begin
            @(posedge clk); #1; n++;
        end
        if (in_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        accept_cyc = cyc;
        in_valid = 1'b0;
        for (int b = 0; b < 8; b++) begin
            int a;
            a = absm(int'($signed(v[b])));
            model_acc[b] += a;
            if (a > model_peak[b]) model_peak[b] = a;
        end
        model_cnt++;
        if (model_cnt == WIN) begin
            for (int b = 0; b < 8; b++) begin
                e.band = b;
                e.data = model_acc[b] / WIN;
                e.last = (b == 7);
                e.peak = model_peak[b];
                sb.push_back(e);
                model_acc[b]  = 0;
                model_peak[b] = 0;
            end
            model_cnt = 0;
        end
    endtask

    // consume nwords level words, optionally stalling lvl_ready on one band
    task automatic expect_dump(input int nwords, input int stall_band, input int stall_cyc);
        exp_t e;
        int n;
        for (int w = 0; w < nwords; w++) begin
            lvl_ready = 1'b1;
            n = 0;
            while (lvl_valid !== 1'b1 && n < CYC_LIM) begin
                @(posedge clk); #1; n++;
            end
            checks++;
            if (lvl_valid !== 1'b1) begin
                errors++;
                $display("FAIL dump_timeout: word %0d lvl_valid=%b required 1", w, lvl_valid);
                return;
            end
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_empty: unexpected word band=%0d data=%0d", lvl_band, lvl_data);
                return;
            end
            e = sb.pop_front();
            if (w == stall_band && stall_cyc > 0) begin
                lvl_ready = 1'b0;
                for (int c = 0; c < stall_cyc; c++) begin
                    @(posedge clk); #1;
                    checks++;
                    if (lvl_valid !== 1'b1 || lvl_band !== e.band[2:0] || lvl_data !== e.data[15:0]
                        || lvl_last !== e.last || in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_hold: cycle %0d valid=%b band=%0d data=%0d in_ready=%b required 1/%0d/%0d/0",
                                 c, lvl_valid, lvl_band, lvl_data, in_ready, e.band, e.data);
                    end
                end
                lvl_ready = 1'b1;
            end
            checks++;
            if (lvl_band !== e.band[2:0]) begin
                errors++;
                $display("FAIL lvl_band: word %0d got %0d required %0d", w, lvl_band, e.band);
            end
            checks++;
            if (lvl_data !== e.data[15:0]) begin
                errors++;
                $display("FAIL lvl_data: band %0d got %0d required %0d", e.band, lvl_data, e.data);
            end
            checks++;
            if (lvl_last !== e.last) begin
                errors++;
                $display("FAIL lvl_last: band %0d got %b required %b", e.band, lvl_last, e.last);
            end
`ifdef EQ_METER_PEAK_EN
            checks++;
            if (lvl_peak !== e.peak[15:0]) begin
                errors++;
                $display("FAIL lvl_peak: band %0d got %0d required %0d", e.band, lvl_peak, e.peak);
            end
`endif
            @(posedge clk); #1;
        end
        if (nwords == 8) begin
            checks++;
            if (lvl_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL dump_end: lvl_valid=%b in_ready=%b required 0/1", lvl_valid, in_ready);
            end
        end
        lvl_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || lvl_valid !== 1'b0 || lvl_band !== 3'd0 || lvl_data !== 16'd0 || lvl_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b valid=%b band=%0d data=%0d last=%b required 1/0/0/0/0",
                     in_ready, lvl_valid, lvl_band, lvl_data, lvl_last);
        end
`ifdef EQ_METER_PEAK_EN
        checks++;
        if (lvl_peak !== 16'd0) begin
            errors++;
            $display("FAIL reset_peak: got %0d required 0", lvl_peak);
        end
`endif
        rst_n = 1'b1;
        model_clear();
        @(posedge clk); #1;
    endtask

    task automatic test_constant();
        vec_t v;
        for (int b = 0; b < 8; b++) v[b] = 16'(100 * (b + 1));
        for (int s = 0; s < WIN; s++) put_sample(v);
        expect_dump(8, -1, 0);
    endtask

    task automatic test_sign_sat();
        vec_t v;
        for (int s = 0; s < WIN; s++) begin
            v = '0;
            v[0] = (s % 2 == 0) ? 16'(1000) : 16'(-1000);
            v[1] = 16'h8000;
            put_sample(v);
        end
        expect_dump(8, -1, 0);
    endtask

    task automatic test_backpressure();
        vec_t v;
        for (int s = 0; s < WIN; s++) begin
            for (int b = 0; b < 8; b++) v[b] = 16'(b * 300 - 1000 + s * 7);
            put_sample(v);
        end
        expect_dump(8, 3, 5);
    endtask

    // in_valid stays high; each accept must come exactly 9 cycles after the previous one
    task automatic test_back_to_back();
        vec_t v;
        int prev;
        for (int w = 0; w < 2; w++) begin
            for (int s = 0; s < WIN; s++) begin
                for (int b = 0; b < 8; b++) v[b] = 16'($urandom());
                put_sample(v);
                if (s > 0) begin
                    checks++;
                    if (accept_cyc - prev != 9) begin
                        errors++;
                        $display("FAIL accept_spacing: window %0d sample %0d got %0d cycles required 9",
                                 w, s, accept_cyc - prev);
                    end
                end
                prev = accept_cyc;
            end
            expect_dump(8, -1, 0);
        end
    endtask

    task automatic test_reset_mid_dump();
        vec_t v;
        for (int b = 0; b < 8; b++) v[b] = 16'(1000 + b);
        for (int s = 0; s < WIN; s++) put_sample(v);
        expect_dump(3, -1, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (lvl_valid !== 1'b0 || in_ready !== 1'b1 || lvl_band !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_dump: lvl_valid=%b in_ready=%b band=%0d required 0/1/0",
                     lvl_valid, in_ready, lvl_band);
        end
        rst_n = 1'b1;
        model_clear();
        for (int b = 0; b < 8; b++) v[b] = 16'(50);
        for (int s = 0; s < WIN; s++) put_sample(v);
        expect_dump(8, -1, 0);
    endtask

`ifdef EQ_METER_PEAK_EN
    task automatic test_peak();
        vec_t v;
        int seq [4];
        seq = '{10, -900, 30, 40};
        for (int s = 0; s < WIN; s++) begin
            v = '0;
            v[5] = 16'(seq[s]);
            put_sample(v);
        end
        checks++;
        if (sb.size() != 8 || sb[5].data != 245 || sb[5].peak != 900) begin
            errors++;
            $display("FAIL peak_model: band5 mean/peak model disagrees with 245/900");
        end
        expect_dump(8, -1, 0);
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        lvl_ready = 1'b0;
        band      = '0;
        test_reset();
        test_constant();
        test_sign_sat();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_dump();
`ifdef EQ_METER_PEAK_EN
        test_peak();
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d words never produced, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

endmodule
